exec_sched: RTL and testbench
=============================

# exec_sched

In-order issue/completion scheduler for the execute stage. It routes each decoded instruction to one of `UNITS` functional units (misc, ALU, later PCRel and Mem) and records the unit id in a completion queue. Unit results are released onto the single writeback port strictly in dispatch order, so units of different or variable latency cannot reorder writeback. `flush` discards all in-flight bookkeeping.

## Interface
Parameters:
- `UNITS`, default 2: number of functional units. Unit ids run 0..UNITS-1.
- `DEPTH`, default 4: number of completion-queue entries, i.e. the maximum number of in-flight instructions. Must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  discards all in-flight instructions.
- `decoded`  decoupled.in  decoded_instr  incoming instruction stream.
- `unit_req_valid`  out  UNITS  one-hot issue request to the target unit.
- `unit_req_ready`  in  UNITS  per-unit accept signal.
- `unit_req_data`  out  decoded_instr  issue payload, broadcast to all units (equals `decoded.data`).
- `unit_res_valid`  in  UNITS  per-unit result valid.
- `unit_res_ready`  out  UNITS  per-unit result accept.
- `unit_res_data`  in  UNITS x exec_result  per-unit result payload.
- `result`  decoupled.out  exec_result  writeback stream, in program order.
- `inflight`  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- Target selection: `tgt = unit_of(decoded.data.op)`. An op that maps to no unit goes to the misc unit (id 0).
- Dispatch fires when `decoded.valid & unit_req_ready[tgt] & !full & !flush`.
  - `unit_req_valid[tgt] = decoded.valid & !full & !flush`. All other bits of `unit_req_valid` are 0.
  - `decoded.ready` equals the dispatch-fire condition without the `decoded.valid` term.
  - On fire, `tgt` is pushed at `wptr`.
- Completion queue: `DEPTH` entries of unit ids, with `wptr`, `rptr` and `count`.
  - Pointers wrap modulo `DEPTH`.
  - `full = (count == DEPTH)`; `empty = (count == 0)`.
- Head unit `h = q[rptr]`, valid only when `!empty`.
  - `result.valid = !empty & unit_res_valid[h] & !flush`.
  - `result.data = unit_res_data[h]`.
  - `unit_res_ready[h] = result.ready & !empty & !flush`. All other bits are 0.
  - Non-head units holding a valid result must keep it stable until they become head.
- Pop fires when `result.valid & result.ready`; `rptr` advances.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full queue: dispatch is blocked even if a pop happens in the same cycle. This keeps any combinational path from `result.ready` to `decoded.ready` out of the design.
- Flush: in the flush cycle nothing dispatches and nothing pops. At the next edge `wptr`, `rptr` and `count` go to 0. Units are flushed by the same signal.
- Error condition: `unit_res_valid[i]` while the queue contains no entry for unit `i`. The bench flags this with an assertion; the RTL ignores it (ready stays 0).

## Timing
- Reset (`rst` low, asynchronous): `wptr = rptr = count = 0`. Outputs during reset:
  - `result.valid = 0`
  - `unit_req_valid = 0`
  - `unit_res_ready = 0`
  - `decoded.ready = 1`, gated by the target unit's ready
  - `inflight = 0`
- Dispatch adds zero cycles: the issue handshake is combinational from `decoded` to the unit. The queue entry becomes visible at the next edge.
- Completion adds zero cycles: a head-unit result is presented on `result` in the cycle it is valid.
- An instruction dispatched in cycle N can therefore retire no earlier than cycle N+1.
- `inflight` is registered and reflects `count` after the last edge.
- Reset release mid-stream: queue state is lost by definition. Upstream must also reset.

## Structure
- Shared package `exec_pkg`:
  - `unit_id_t`
  - unit id constants `UNIT_MISC = 0`, `UNIT_ALU = 1`
  - function `unit_of(instr_op) -> unit_id_t`, mapping INVAL/JALR/LUI to MISC and OP/OP_IMM to ALU
- `decoded_instr` and `exec_result` remain in the existing types.
- Natural sub-module: `id_fifo`, a parameterised FIFO of `unit_id_t` with push, pop, clear (flush), full, empty and count.
- The scheduler top holds the select/mux logic only.

## Test plan
- Reset, then an ALU op with a 1-cycle ALU: dispatch in cycle 1, `result.valid` in cycle 2, `inflight` goes 0 -> 1 -> 0.
- Dispatch misc (3-cycle latency) then ALU (1-cycle): the ALU result is held with `unit_res_ready[1] = 0` until the misc result pops. Writeback order is misc then ALU.
- Fill 4 entries with `result.ready = 0`: `decoded.ready = 0` at `inflight = 4`. Raise `result.ready`: the full flag still blocks dispatch in the pop cycle, and dispatch resumes the cycle after.
- Continuous back-to-back ALU ops with `result.ready = 1`: one dispatch and one retire per cycle, `inflight` holds at 1, pointers wrap past entry 3 without loss.
- Assert `flush` with 3 in flight: no pop in the flush cycle, `inflight = 0` the next cycle, and the next dispatch writes queue entry 0.
- Assert `rst` asynchronously mid-cycle with 2 in flight: `result.valid` and `unit_req_valid` drop immediately, and `inflight = 0`.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage types: instruction ops, issue/result payloads,
// functional-unit ids and the op-to-unit routing function.
package exec_pkg;

    localparam int UID_W = 2;

    typedef logic [UID_W-1:0] unit_id_t;

    localparam unit_id_t UNIT_MISC = 2'd0;
    localparam unit_id_t UNIT_ALU  = 2'd1;

    typedef enum logic [2:0] {
        INVAL,
        JALR,
        LUI,
        AUIPC,
        OP,
        OP_IMM,
        LOAD,
        STORE
    } instr_op;

    typedef struct packed {
        instr_op     op;
        logic [4:0]  rd;
        logic [31:0] operand;
    } decoded_instr;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } exec_result;

    // PCRel and Mem ops fall back to misc until those units exist
    function automatic unit_id_t unit_of(instr_op op);
        unit_id_t u;
        u = UNIT_MISC;
        case (op)
            OP, OP_IMM: u = UNIT_ALU;
            default:    u = UNIT_MISC;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/exec_sched_if.sv
// Decoded-instruction input stream and writeback output stream
// of the execute scheduler.
interface exec_sched_if;
    import exec_pkg::*;

    logic         dec_valid;
    logic         dec_ready;
    decoded_instr dec_data;

    logic         res_valid;
    logic         res_ready;
    exec_result   res_data;

    modport master (
        output dec_valid, dec_data,
        input  dec_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport slave (
        input  dec_valid, dec_data,
        output dec_ready,
        output res_valid, res_data,
        input  res_ready
    );

endinterface

// File: rtl/exec_sched_id_fifo.sv
// Completion queue of unit ids in dispatch order.
// DEPTH must be a power of two so pointers wrap for free.
module id_fifo
    import exec_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  unit_id_t      data_i,
    output unit_id_t      data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    unit_id_t      mem_q [DEPTH];

    logic do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/exec_sched.sv
// In-order issue/completion scheduler: routes instructions to units and
// releases their results on one writeback port in dispatch order.
module exec_sched
    import exec_pkg::*;
#(
    parameter  int UNITS = 2,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    exec_sched_if.slave      bus,
    output logic [UNITS-1:0] unit_req_valid_o,
    input  logic [UNITS-1:0] unit_req_ready_i,
    output decoded_instr     unit_req_data_o,
    input  logic [UNITS-1:0] unit_res_valid_i,
    output logic [UNITS-1:0] unit_res_ready_o,
    input  exec_result       unit_res_data_i [UNITS],
    output logic [CW-1:0]    inflight_o
);

    unit_id_t tgt;
    unit_id_t head;
    logic     full, empty;
    logic     can_issue, head_ok;
    logic     tgt_ready, head_valid;
    logic     push, pop;

    // Full blocks issue even on a pop cycle: no result.ready -> decoded.ready path
    assign can_issue = ~full & ~flush_i;
    assign head_ok   = ~empty & ~flush_i;

    always_comb begin
        tgt = unit_of(bus.dec_data.op);
        if (int'(tgt) >= UNITS) tgt = UNIT_MISC;
    end

    always_comb begin
        unit_req_valid_o = '0;
        unit_res_ready_o = '0;
        tgt_ready        = 1'b0;
        head_valid       = 1'b0;
        bus.res_data     = '0;
        for (int i = 0; i < UNITS; i++) begin
            if (tgt == unit_id_t'(i)) begin
                unit_req_valid_o[i] = bus.dec_valid & can_issue;
                tgt_ready           = unit_req_ready_i[i];
            end
            if (head == unit_id_t'(i)) begin
                head_valid          = unit_res_valid_i[i];
                bus.res_data        = unit_res_data_i[i];
                unit_res_ready_o[i] = bus.res_ready & head_ok;
            end
        end
    end

    assign unit_req_data_o = bus.dec_data;
    assign bus.dec_ready   = can_issue & tgt_ready;
    assign bus.res_valid   = head_ok & head_valid;

    assign push = bus.dec_valid & bus.dec_ready;
    assign pop  = bus.res_valid & bus.res_ready;

    id_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .data_i  (tgt),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (inflight_o)
    );

endmodule

// File: tb/tb_exec_sched.sv
// Directed bench for exec_sched with behavioural units and an
// in-order completion model checked every cycle.
module tb_exec_sched;
    import exec_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic [1:0]   req_valid, req_ready, res_valid_u, res_ready_u;
    decoded_instr req_data;
    exec_result   res_data_u [2];
    logic [2:0]   inflight;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exec_sched_if bus ();

    exec_sched #(
        .UNITS (2),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .bus              (bus),
        .unit_req_valid_o (req_valid),
        .unit_req_ready_i (req_ready),
        .unit_req_data_o  (req_data),
        .unit_res_valid_i (res_valid_u),
        .unit_res_ready_o (res_ready_u),
        .unit_res_data_i  (res_data_u),
        .inflight_o       (inflight)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tb_unit(instr_op op);
        return (op == OP) || (op == OP_IMM);
    endfunction

    // ---------------- functional units: misc latency 3, ALU latency 1
    typedef struct {
        exec_result r;
        int         due;
    } job_t;

    job_t uq0[$];
    job_t uq1[$];
    int   lat [2];
    int   cyc = 0;

    task automatic unit_refresh();
        res_valid_u = '0;
        res_data_u  = '{default: '0};
        if (uq0.size() > 0) begin
            res_valid_u[0] = (uq0[0].due <= cyc);
            res_data_u[0]  = uq0[0].r;
        end
        if (uq1.size() > 0) begin
            res_valid_u[1] = (uq1[0].due <= cyc);
            res_data_u[1]  = uq1[0].r;
        end
    endtask

    always @(negedge rst_n) begin
        uq0.delete();
        uq1.delete();
        unit_refresh();
    end

    initial begin : env
        logic [1:0]   acc, ret;
        logic         fl, rs;
        decoded_instr d;
        job_t         j;
        lat = '{3, 1};
        unit_refresh();
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            ret = res_valid_u & res_ready_u;
            fl  = flush;
            d   = req_data;
            @(posedge clk);
            rs = rst_n;
            #1;
            cyc++;
            if (!rs || fl) begin
                uq0.delete();
                uq1.delete();
            end else begin
                if (ret[0]) void'(uq0.pop_front());
                if (ret[1]) void'(uq1.pop_front());
                j.r.rd    = d.rd;
                j.r.value = d.operand;
                if (acc[0]) begin
                    j.due = cyc - 1 + lat[0];
                    uq0.push_back(j);
                end
                if (acc[1]) begin
                    j.due = cyc - 1 + lat[1];
                    uq1.push_back(j);
                end
            end
            unit_refresh();
        end
    end

    // ---------------- completion model: program-order queue of (unit, value)
    logic        mq_u[$];
    logic [31:0] mq_v[$];

    initial begin : cmp
        logic        tu, h, exp_rdy, exp_rv, do_push, do_pop, fl, rs, hit;
        logic [1:0]  exp_reqv, exp_resr;
        logic [31:0] pv;
        forever begin
            @(negedge clk);
            do_push = 1'b0;
            do_pop  = 1'b0;
            fl      = 1'b0;
            tu      = tb_unit(bus.dec_data.op);
            if (!rst_n) begin
                mq_u.delete();
                mq_v.delete();
                check("m_rst_res_valid", bus.res_valid, 0);
                check("m_rst_req_valid", req_valid, 0);
                check("m_rst_res_ready", res_ready_u, 0);
                check("m_rst_inflight", inflight, 0);
                check("m_rst_dec_ready", bus.dec_ready, req_ready[tu]);
            end else begin
                exp_rdy  = (mq_u.size() < DEPTH) && !flush && req_ready[tu];
                exp_reqv = '0;
                if (bus.dec_valid && mq_u.size() < DEPTH && !flush)
                    exp_reqv[tu] = 1'b1;
                exp_rv   = 1'b0;
                exp_resr = '0;
                h        = 1'b0;
                if (mq_u.size() > 0 && !flush) begin
                    h           = mq_u[0];
                    exp_rv      = res_valid_u[h];
                    exp_resr[h] = bus.res_ready;
                end
                check("m_dec_ready", bus.dec_ready, exp_rdy);
                check("m_req_valid", req_valid, exp_reqv);
                check("m_req_data", req_data, bus.dec_data);
                check("m_res_valid", bus.res_valid, exp_rv);
                check("m_res_ready", res_ready_u, exp_resr);
                check("m_inflight", inflight, mq_u.size());
                if (exp_rv) begin
                    check("m_res_data", bus.res_data, res_data_u[h]);
                    check("m_prog_order", bus.res_data.value, mq_v[0]);
                end
                for (int i = 0; i < 2; i++) begin
                    if (res_valid_u[i]) begin
                        hit = 1'b0;
                        foreach (mq_u[k]) if (mq_u[k] == i[0]) hit = 1'b1;
                        check("orphan_result", hit, 1);
                    end
                end
                do_push = bus.dec_valid && exp_rdy;
                do_pop  = exp_rv && bus.res_ready;
                fl      = flush;
                pv      = bus.dec_data.operand;
            end
            @(posedge clk);
            rs = rst_n;
            if (!rs || fl) begin
                mq_u.delete();
                mq_v.delete();
            end else begin
                if (do_pop) begin
                    void'(mq_u.pop_front());
                    void'(mq_v.pop_front());
                end
                if (do_push) begin
                    mq_u.push_back(tu);
                    mq_v.push_back(pv);
                end
            end
        end
    end

    // ---------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, instr_op op, logic [31:0] val);
        bus.dec_valid        = v;
        bus.dec_data.op      = op;
        bus.dec_data.rd      = val[4:0];
        bus.dec_data.operand = val;
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while (inflight != 0 && n < 30) begin
            step();
            n++;
        end
        check(name, (n < 30), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.dec_valid = 1'b0;
        bus.dec_data  = '0;
        bus.res_ready = 1'b1;
        req_ready     = 2'b11;
        drive(0, OP, 0);

        @(negedge clk);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_res_ready", res_ready_u, 0);
        check("rst_inflight", inflight, 0);
        check("rst_dec_ready", bus.dec_ready, 1);
        step();
        rst_n = 1'b1;

        // single ALU op
        step(); drive(1, OP, 100);
        @(negedge clk);
        check("t1_dec_ready", bus.dec_ready, 1);
        check("t1_req_valid", req_valid, 2'b10);
        check("t1_inflight0", inflight, 0);
        step(); drive(0, OP, 0);
        @(negedge clk);
        check("t1_res_valid", bus.res_valid, 1);
        check("t1_res_value", bus.res_data.value, 100);
        check("t1_inflight1", inflight, 1);
        step();
        @(negedge clk);
        check("t1_inflight2", inflight, 0);

        // slow misc before fast ALU
        step(); drive(1, LUI, 200);
        @(negedge clk);
        check("t2_req_misc", req_valid, 2'b01);
        step(); drive(1, OP, 201);
        step(); drive(0, OP, 0);
        @(negedge clk);
        check("t2_alu_ready", res_valid_u[1], 1);
        check("t2_alu_held", res_ready_u, 2'b01);
        check("t2_wait_misc", bus.res_valid, 0);
        step();
        @(negedge clk);
        check("t2_first", bus.res_data.value, 200);
        step();
        @(negedge clk);
        check("t2_second", bus.res_data.value, 201);
        check("t2_second_v", bus.res_valid, 1);
        step();
        @(negedge clk);
        check("t2_empty", inflight, 0);

        // fill to full with writeback stalled
        bus.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); drive(1, OP_IMM, 300 + k);
        end
        step(); drive(1, OP, 304);
        @(negedge clk);
        check("t3_full_inflight", inflight, 4);
        check("t3_full_block", bus.dec_ready, 0);
        step(); bus.res_ready = 1'b1;
        @(negedge clk);
        check("t3_pop_block", bus.dec_ready, 0);
        check("t3_pop_valid", bus.res_valid, 1);
        check("t3_pop_value", bus.res_data.value, 300);
        step();
        @(negedge clk);
        check("t3_resume", bus.dec_ready, 1);
        check("t3_inflight", inflight, 3);
        step(); drive(0, OP, 0);
        drain("t3_drain");

        // back-to-back ALU stream
        for (int k = 0; k < 10; k++) begin
            step(); drive(1, OP, 400 + k);
            @(negedge clk);
            if (k > 0) begin
                check("t4_inflight", inflight, 1);
                check("t4_value", bus.res_data.value, 400 + k - 1);
            end
        end
        step(); drive(0, OP, 0);
        drain("t4_drain");

        // flush with 3 in flight
        bus.res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); drive(1, OP, 500 + k);
        end
        step(); drive(1, OP, 503);
        flush = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("t5_fl_dec_ready", bus.dec_ready, 0);
        check("t5_fl_req_valid", req_valid, 0);
        check("t5_fl_res_valid", bus.res_valid, 0);
        check("t5_fl_res_ready", res_ready_u, 0);
        check("t5_fl_inflight", inflight, 3);
        step(); flush = 1'b0; drive(0, OP, 0);
        @(negedge clk);
        check("t5_inflight", inflight, 0);
        check("t5_wptr0", dut.u_fifo.wptr_q, 0);
        step(); drive(1, JALR, 600);
        step(); drive(0, OP, 0);
        @(negedge clk);
        check("t5_wptr1", dut.u_fifo.wptr_q, 1);
        check("t5_inflight1", inflight, 1);
        drain("t5_drain");

        // async reset with 2 in flight
        bus.res_ready = 1'b0;
        step(); drive(1, OP, 700);
        step(); drive(1, OP, 701);
        step(); drive(0, OP, 0);
        #1;
        check("t6_pre_valid", bus.res_valid, 1);
        check("t6_pre_inflight", inflight, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_res_valid", bus.res_valid, 0);
        check("t6_req_valid", req_valid, 0);
        check("t6_inflight", inflight, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_inflight", inflight, 0);
        step(); drive(1, OP, 800); bus.res_ready = 1'b1;
        step(); drive(0, OP, 0);
        @(negedge clk);
        check("t6_after_value", bus.res_data.value, 800);
        step();
        @(negedge clk);
        check("t6_after_empty", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
